// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and helpers for the flappy game control slice.
package flappy_pkg;

    localparam int unsigned BIRD_X    = 200;
    localparam int unsigned BIRD_SZ   = 16;
    localparam int unsigned TUBE_W    = 60;
    localparam int unsigned GAP_H     = 60;
    localparam int unsigned GROUND_Y  = 460;
    localparam int unsigned HIT_TICKS = 20;
    localparam int unsigned OVER_LOCK = 10;
    localparam int unsigned NUM_TUBES = 3;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_PLAY  = 2'd1,
        ST_HIT   = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Lower bound of a window, clamped at 0 instead of wrapping.
    function automatic logic [10:0] clamp_sub(input logic [10:0] a, input logic [10:0] b);
        return (a < b) ? 11'd0 : a - b;
    endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Game-control bus: bird/tube geometry and score in, game state out.
interface game_state_ctrl_if;
    logic       flap;
    logic [9:0] bird_y;
    logic [9:0] tube1_x_pos, tube2_x_pos, tube3_x_pos;
    logic [9:0] tube1_y_pos, tube2_y_pos, tube3_y_pos;
    logic [7:0] score;
    logic       game_end;
    logic [1:0] state;
    logic       hit_flash;
    logic [7:0] best_score;
    logic       restart;

    modport master (
        output flap, bird_y, tube1_x_pos, tube2_x_pos, tube3_x_pos,
               tube1_y_pos, tube2_y_pos, tube3_y_pos, score,
        input  game_end, state, hit_flash, best_score, restart
    );
    modport slave (
        input  flap, bird_y, tube1_x_pos, tube2_x_pos, tube3_x_pos,
               tube1_y_pos, tube2_y_pos, tube3_y_pos, score,
        output game_end, state, hit_flash, best_score, restart
    );
endinterface

// File: rtl/tube_hit_check.sv
// Combinational bird-vs-tube test: hit when the bird overlaps the tube columns
// but is not wholly inside the gap.
module tube_hit_check
    import flappy_pkg::*;
(
    input  logic [9:0] bird_x_i,
    input  logic [9:0] bird_y_i,
    input  logic [9:0] tube_x_i,
    input  logic [9:0] tube_y_i,
    output logic       hit_o
);
    localparam logic [10:0] SZ  = 11'(BIRD_SZ);
    localparam logic [10:0] TW  = 11'(TUBE_W);
    localparam logic [10:0] GH  = 11'(GAP_H);

    logic [10:0] bx, by, tx, ty, lo_x, lo_y;
    logic        col_ovl, in_gap;

    always_comb begin
        bx      = {1'b0, bird_x_i};
        by      = {1'b0, bird_y_i};
        tx      = {1'b0, tube_x_i};
        ty      = {1'b0, tube_y_i};
        lo_x    = clamp_sub(tx, TW);
        lo_y    = clamp_sub(ty, GH);
        col_ovl = (bx < tx) && (lo_x < bx + SZ);
        in_gap  = (by >= lo_y) && (by + SZ <= ty + GH);
        hit_o   = col_ovl && !in_gap;
    end
endmodule

// File: rtl/game_state_ctrl.sv
// Game state FSM: READY/PLAY/HIT/OVER with registered collision and best score.
// Build option: define COLLISION_CEILING_EN to treat bird_y == 0 as a collision.
module game_state_ctrl
    import flappy_pkg::*;
(
    input  logic              clk10,
    input  logic              clr,
    game_state_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(HIT_TICKS - 1);
    localparam logic [CNT_W-1:0] LOCK     = CNT_W'(OVER_LOCK);

    logic [NUM_TUBES-1:0][9:0] tx, ty;
    logic [NUM_TUBES-1:0]      tube_hit;
    logic                      ground, ceil, coll_d, coll_q;
    state_e                    state_d, state_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q, hit_elapsed;
    logic [7:0]                best_d, best_q;
    logic                      game_end_q, restart_q;

    assign tx = {bus.tube3_x_pos, bus.tube2_x_pos, bus.tube1_x_pos};
    assign ty = {bus.tube3_y_pos, bus.tube2_y_pos, bus.tube1_y_pos};

    for (genvar t = 0; t < NUM_TUBES; t++) begin : g_tube
        tube_hit_check u_chk (
            .bird_x_i (10'(BIRD_X)),
            .bird_y_i (bus.bird_y),
            .tube_x_i (tx[t]),
            .tube_y_i (ty[t]),
            .hit_o    (tube_hit[t])
        );
    end

    assign ground = ({1'b0, bus.bird_y} + 11'(BIRD_SZ)) > 11'(GROUND_Y);
`ifdef COLLISION_CEILING_EN
    assign ceil = (bus.bird_y == 10'd0);
`else
    assign ceil = 1'b0;
`endif
    assign coll_d = (|tube_hit) | ground | ceil;

    // cnt_q counts down through HIT, then counts up (saturating) through OVER.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        unique case (state_q)
            ST_READY: if (bus.flap) state_d = ST_PLAY;
            ST_PLAY: begin
                if (coll_q) begin
                    state_d = ST_HIT;
                    cnt_d   = HIT_LAST;
                end
            end
            ST_HIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_OVER;
                    cnt_d   = '0;
                    if (bus.score > best_q) best_d = bus.score;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_OVER: begin
                if (bus.flap && cnt_q >= LOCK) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else if (cnt_q < LOCK) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk10) begin
        if (clr) begin
            state_q    <= ST_READY;
            cnt_q      <= '0;
            best_q     <= '0;
            coll_q     <= 1'b0;
            game_end_q <= 1'b1;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            coll_q     <= coll_d;
            game_end_q <= (state_d != ST_PLAY);
            restart_q  <= (state_q == ST_OVER) && (state_d == ST_READY);
        end
    end

    assign hit_elapsed    = HIT_LAST - cnt_q;
    assign bus.hit_flash  = (state_q == ST_HIT) && hit_elapsed[1];
    assign bus.state      = state_q;
    assign bus.game_end   = game_end_q;
    assign bus.best_score = best_q;
    assign bus.restart    = restart_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomised + directed bench for game_state_ctrl with a scoreboard and a
// rule-level reference model of the game flow.
module tb_game_state_ctrl;
    logic clk10 = 1'b0;
    logic clr;
    game_state_ctrl_if ifc ();

    game_state_ctrl dut (.clk10(clk10), .clr(clr), .bus(ifc));

    always #5 clk10 = ~clk10;

    typedef struct packed {
        logic [1:0] st;
        logic       ge;
        logic       fl;
        logic [7:0] best;
        logic       rs;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // stimulus values
    int by = 230;
    int tx[3] = '{600, 600, 600};
    int ty[3] = '{240, 240, 240};
    int sc = 0;

    // model state: phase, cycles elapsed in HIT / OVER, best, restart, pending collision
    int m_st = 0, m_el = 0, m_ov = 0, m_best = 0;
    bit m_rs = 0, m_coll = 0;

    function automatic bit tube_blocks(int b, int x, int y);
        int  lo_x = (x < 60) ? 0 : x - 60;
        int  lo_y = (y < 60) ? 0 : y - 60;
        bit  ov   = (200 < x) && (lo_x < 216);
        bit  ins  = (b >= lo_y) && (b + 16 <= y + 60);
        return ov && !ins;
    endfunction

    function automatic bit collide();
        bit c = (by + 16 > 460);
        for (int i = 0; i < 3; i++) c |= tube_blocks(by, tx[i], ty[i]);
`ifdef COLLISION_CEILING_EN
        if (by == 0) c = 1;
`endif
        return c;
    endfunction

    task automatic model(input bit c, input bit f);
        bit nc;
        if (c) begin
            m_st = 0; m_el = 0; m_ov = 0; m_best = 0; m_coll = 0; m_rs = 0;
        end else begin
            nc   = collide();
            m_rs = 0;
            case (m_st)
                0: if (f) m_st = 1;
                1: if (m_coll) begin m_st = 2; m_el = 0; end
                2: if (m_el == 19) begin
                       m_st = 3; m_ov = 0;
                       if (sc > m_best) m_best = sc;
                   end else m_el++;
                default: if (f && m_ov >= 10) begin m_st = 0; m_rs = 1; end
                         else m_ov++;
            endcase
            m_coll = nc;
        end
    endtask

    task automatic step(input bit c, input bit f);
        exp_t e;
        clr             = c;
        ifc.flap        = f;
        ifc.bird_y      = 10'(by);
        ifc.tube1_x_pos = 10'(tx[0]); ifc.tube1_y_pos = 10'(ty[0]);
        ifc.tube2_x_pos = 10'(tx[1]); ifc.tube2_y_pos = 10'(ty[1]);
        ifc.tube3_x_pos = 10'(tx[2]); ifc.tube3_y_pos = 10'(ty[2]);
        ifc.score       = 8'(sc);
        model(c, f);
        e.st   = 2'(m_st);
        e.ge   = (m_st != 1);
        e.fl   = (m_st == 2) && (((m_el / 2) % 2) == 1);
        e.best = 8'(m_best);
        e.rs   = m_rs;
        expq.push_back(e);
        @(posedge clk10);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // monitor: one expected snapshot per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk10);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("state",      int'(ifc.state),      int'(e.st));
                chk("game_end",   int'(ifc.game_end),   int'(e.ge));
                chk("hit_flash",  int'(ifc.hit_flash),  int'(e.fl));
                chk("best_score", int'(ifc.best_score), int'(e.best));
                chk("restart",    int'(ifc.restart),    int'(e.rs));
            end
        end
    end

    task automatic hit_until_over();
        for (int i = 0; i < 40 && m_st != 3; i++) step(0, 1);
    endtask

    task automatic round(input int score_v, input int hit_by, input bit pulse);
        sc = score_v; by = 230;
        step(0, 1);
        repeat (3) step(0, 0);
        tx[0] = 230; ty[0] = 240;
        repeat (3) step(0, 0);
        by = hit_by; step(0, 0); by = 230;
        for (int i = 0; i < 30 && m_st == 1; i++) step(0, 1);
        if (m_st == 1) begin
            by = 450; step(0, 0); by = 230;
        end
        hit_until_over();
        if (pulse) begin
            for (int k = 0; k < 30 && m_st != 0; k++) step(0, (k == 5) || (k == 10));
        end else begin
            for (int k = 0; k < 30 && m_st != 0; k++) step(0, 1);
        end
        tx[0] = 600;
        repeat (2) step(0, 0);
    endtask

    initial begin
        clr = 1'b1;
        ifc.flap = 1'b0;
        step(1, 0);
        step(1, 1);
        round(5, 170, 0);
        round(7, 450, 1);
        round(7, 170, 1);
        round(3, 0, 1);
        round(200, 450, 1);
        // clr while in HIT with flap high
        sc = 9; step(0, 1);
        by = 450; step(0, 0); by = 230;
        repeat (6) step(0, 1);
        step(1, 1);
        repeat (3) step(0, 0);
        // randomised play
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                by = 230;
                for (int i = 0; i < 3; i++) begin tx[i] = 600; ty[i] = 240; end
            end else begin
                by = $urandom_range(0, 479);
                for (int i = 0; i < 3; i++) begin
                    tx[i] = $urandom_range(0, 700);
                    ty[i] = $urandom_range(0, 479);
                end
            end
            if ($urandom_range(0, 15) == 0) sc = $urandom_range(0, 255);
            step($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0);
        end
        @(posedge clk10);
        #3;
        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
